// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: registered N:1 valid/ready stream mux with fixed-select and round-robin modes
// Optional feature macro: MUX_PKT_LOCK_EN (packet lock via w_last/f_last, no interleaving)
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   w, w_valid, w_ready m channels of n-bit data with handshake (w_ready combinational)
//   s, mode             channel select (mode=0) / round-robin enable (mode=1)
//   f, f_valid, f_ready registered output beat with handshake
//   f_ch                channel index that produced f
//   w_last, f_last      packet end markers (MUX_PKT_LOCK_EN only)
module mux_nx1_stream #(
  parameter int n = 8,
  parameter int m = 4,
  localparam int cw = (m > 1) ? $clog2(m) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [m*n-1:0] w,
  input  logic [m-1:0]   w_valid,
  output logic [m-1:0]   w_ready,
  input  logic [cw-1:0]  s,
  input  logic           mode,
`ifdef MUX_PKT_LOCK_EN
  input  logic [m-1:0]   w_last,
  output logic           f_last,
`endif
  output logic [n-1:0]   f,
  output logic           f_valid,
  input  logic           f_ready,
  output logic [cw-1:0]  f_ch
);
  logic [cw-1:0] rr_ptr, rr_g, g;
  logic rr_hit, gnt, space, load, adv;
  int idx;
`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state_q, state_d;
  logic [cw-1:0] lock_ch_q, lock_ch_d;
`endif
  // first valid channel at or after rr_ptr, wrapping mod m
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    idx = 0;
    for (int i = 0; i < m; i++) begin
      idx = (int'(rr_ptr) + i) % m;
      if (!rr_hit && w_valid[idx]) begin
        rr_hit = 1'b1;
        rr_g = cw'(idx);
      end
    end
  end
  always_comb begin
    g = mode ? rr_g : s;
    gnt = mode ? rr_hit : (int'(s) < m);
    if (m == 1) begin
      g = '0;
      gnt = 1'b1;
    end
`ifdef MUX_PKT_LOCK_EN
    if (state_q == LOCKED) begin
      g = lock_ch_q;
      gnt = 1'b1;
    end
`endif
  end
  assign space = !f_valid || f_ready;
  assign load = gnt && w_valid[g] && space;
`ifdef MUX_PKT_LOCK_EN
  assign adv = load && mode && w_last[g];
`else
  assign adv = load && mode;
`endif
  always_comb begin
    w_ready = '0;
    for (int k = 0; k < m; k++) w_ready[k] = gnt && space && (int'(g) == k);
  end
`ifdef MUX_PKT_LOCK_EN
  // a loaded non-last beat holds the lock on its channel until that channel's last beat
  always_comb begin
    state_d = load ? (w_last[g] ? UNLOCKED : LOCKED) : state_q;
    lock_ch_d = (load && state_q == UNLOCKED) ? g : lock_ch_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNLOCKED;
      lock_ch_q <= '0;
      f_last <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_ch_q <= lock_ch_d;
      if (load) f_last <= w_last[g];
    end
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
      f_valid <= 1'b0;
      f_ch <= '0;
      rr_ptr <= '0;
    end else begin
      if (load) begin
        f <= w[int'(g)*n +: n];
        f_ch <= g;
        f_valid <= 1'b1;
      end else if (f_ready) begin
        f_valid <= 1'b0;
      end
      if (adv) rr_ptr <= (int'(g) == m - 1) ? '0 : g + cw'(1);
    end
  end
endmodule
